// File: rtl/calc_controller_if.sv
// Bus bundle for calc_controller: buttons, operand digits, ALU handshake and
// display drive. The master modport is the controller's view; the slave
// modport is the view of whatever surrounds it (buttons, ALU, display).
interface calc_controller_if;
    logic [8:0]  B;
    logic [3:0]  n1dig1;
    logic [3:0]  n1dig0;
    logic [3:0]  n2dig1;
    logic [3:0]  n2dig0;
    logic [1:0]  alu_op;
    logic        alu_start;
    logic        alu_done;
    logic [13:0] alu_result;
    logic        alu_neg;
    logic [3:0]  num;
    logic [3:0]  enabler;
    logic        dot;
    logic        busy;
    logic        err;

    modport master (
        input  B, alu_done, alu_result, alu_neg,
        output n1dig1, n1dig0, n2dig1, n2dig0, alu_op, alu_start,
               num, enabler, dot, busy, err
    );

    modport slave (
        output B, alu_done, alu_result, alu_neg,
        input  n1dig1, n1dig0, n2dig1, n2dig0, alu_op, alu_start,
               num, enabler, dot, busy, err
    );
endinterface

// File: rtl/calc_controller.sv
// calc_controller: sequencing controller for the two-operand 7-segment
// calculator. Handles operand digit entry from button edges, op selection,
// the start/done ALU handshake, a sequential 14-bit double-dabble to four BCD
// digits, and the four-digit multiplexed display scan.
// Optional feature: define CALC_CTRL_TIMEOUT_EN to bound the wait for the ALU
// to TIMEOUT_CYC cycles (timeout lands in SHOW with err set).
module calc_controller #(
    parameter int SCAN_DIV    = 250000,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst,
    calc_controller_if.master io_bus
);

`ifdef CALC_CTRL_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int WAIT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [2:0] {
        ST_ENTRY,
        ST_LAUNCH,
        ST_WAIT_ALU,
        ST_CONVERT,
        ST_SHOW
    } state_t;

    state_t             r_state;
    state_t             w_nextState;

    logic [8:0]         r_bPrev;
    logic [8:0]         w_edge;
    logic               w_clrEdge;
    logic               w_opEdge;
    logic [1:0]         w_opCode;

    logic [3:0]         r_n1d0;
    logic [3:0]         r_n1d1;
    logic [3:0]         r_n2d0;
    logic [3:0]         r_n2d1;
    logic [1:0]         r_aluOp;

    logic [13:0]        r_bin;
    logic [15:0]        r_bcd;
    logic [11:0]        w_bcdAdj;
    logic [3:0]         r_iter;
    logic               r_neg;
    logic               r_err;

    logic [WAIT_W-1:0]  r_waitCnt;
    logic               w_timeout;

    logic [SCAN_W-1:0]  r_scanCnt;
    logic [1:0]         r_digSel;

    logic [3:0]         w_num;
    logic [3:0]         w_enabler;
    logic               w_dot;
    logic               w_busy;
    logic               w_aluStart;

    function automatic logic [3:0] bcdInc(input logic [3:0] d);
        return (d == 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

    // Rising edges of the button levels; clear outranks everything and the
    // lowest-numbered op button wins when several rise together.
    always_comb begin
        w_edge    = io_bus.B & ~r_bPrev;
        w_clrEdge = w_edge[4];
        w_opEdge  = |w_edge[8:5];
        w_opCode  = 2'd0;
        if (w_edge[5])      w_opCode = 2'd0;
        else if (w_edge[6]) w_opCode = 2'd1;
        else if (w_edge[7]) w_opCode = 2'd2;
        else if (w_edge[8]) w_opCode = 2'd3;
    end

    // Previous button levels, refreshed every cycle for edge detection.
    always_ff @(posedge clk) begin
        if (rst) r_bPrev <= '0;
        else     r_bPrev <= io_bus.B;
    end

    // Timeout fires on the last allowed WAIT_ALU cycle when the feature is on.
    always_comb begin
        w_timeout = TIMEOUT_EN && (r_state == ST_WAIT_ALU) &&
                    (r_waitCnt == WAIT_W'(TIMEOUT_CYC - 1));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_ENTRY;
        else     r_state <= w_nextState;
    end

    // Next-state logic for the entry / launch / wait / convert / show flow.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_ENTRY: begin
                if (!w_clrEdge && w_opEdge) w_nextState = ST_LAUNCH;
            end
            ST_LAUNCH: w_nextState = ST_WAIT_ALU;
            ST_WAIT_ALU: begin
                if (w_clrEdge)            w_nextState = ST_ENTRY;
                else if (io_bus.alu_done) w_nextState = ST_CONVERT;
                else if (w_timeout)       w_nextState = ST_SHOW;
            end
            ST_CONVERT: begin
                if (r_iter == 4'd13) w_nextState = ST_SHOW;
            end
            ST_SHOW: begin
                if (w_clrEdge)     w_nextState = ST_ENTRY;
                else if (w_opEdge) w_nextState = ST_LAUNCH;
            end
            default: w_nextState = ST_ENTRY;
        endcase
    end

    // Operand digits and op code; frozen outside ENTRY and SHOW so the ALU
    // sees stable inputs from launch until conversion ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_n1d0  <= '0;
            r_n1d1  <= '0;
            r_n2d0  <= '0;
            r_n2d1  <= '0;
            r_aluOp <= '0;
        end else begin
            case (r_state)
                ST_ENTRY: begin
                    if (w_clrEdge) begin
                        r_n1d0 <= '0;
                        r_n1d1 <= '0;
                        r_n2d0 <= '0;
                        r_n2d1 <= '0;
                    end else if (w_opEdge) begin
                        r_aluOp <= w_opCode;
                    end else begin
                        if (w_edge[0]) r_n1d0 <= bcdInc(r_n1d0);
                        if (w_edge[1]) r_n1d1 <= bcdInc(r_n1d1);
                        if (w_edge[2]) r_n2d0 <= bcdInc(r_n2d0);
                        if (w_edge[3]) r_n2d1 <= bcdInc(r_n2d1);
                    end
                end
                ST_SHOW: begin
                    if (w_clrEdge) begin
                        r_n1d0 <= '0;
                        r_n1d1 <= '0;
                        r_n2d0 <= '0;
                        r_n2d1 <= '0;
                    end else if (w_opEdge) begin
                        r_aluOp <= w_opCode;
                    end
                end
                default: ;
            endcase
        end
    end

    // Add-3 adjust of the low three BCD nibbles ahead of each shift. The top
    // nibble only ever carries out for results above 9999, which are flagged
    // as errors and blanked anyway.
    always_comb begin
        w_bcdAdj = r_bcd[11:0];
        for (int k = 0; k < 3; k++) begin
            if (r_bcd[4*k +: 4] >= 4'd5) w_bcdAdj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
        end
    end

    // Result capture, error flags and the one-bit-per-cycle double-dabble.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bin  <= '0;
            r_bcd  <= '0;
            r_iter <= '0;
            r_neg  <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            case (r_state)
                ST_WAIT_ALU: begin
                    if (w_clrEdge) begin
                        r_err <= r_err;
                    end else if (io_bus.alu_done) begin
                        r_bin  <= io_bus.alu_result;
                        r_bcd  <= '0;
                        r_iter <= '0;
                        r_neg  <= io_bus.alu_neg;
                        r_err  <= (io_bus.alu_result > 14'd9999) ||
                                  ((r_aluOp == 2'b11) && (r_n2d0 == 4'd0) && (r_n2d1 == 4'd0));
                    end else if (w_timeout) begin
                        r_err <= 1'b1;
                        r_neg <= 1'b0;
                    end
                end
                ST_CONVERT: begin
                    r_bcd  <= {r_bcd[14:12], w_bcdAdj, r_bin[13]};
                    r_bin  <= {r_bin[12:0], 1'b0};
                    r_iter <= r_iter + 4'd1;
                end
                ST_SHOW: begin
                    if (w_clrEdge || w_opEdge) begin
                        r_err <= 1'b0;
                        r_neg <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Cycles spent in WAIT_ALU; restarts whenever the state is left.
    always_ff @(posedge clk) begin
        if (rst)                           r_waitCnt <= '0;
        else if (r_state != ST_WAIT_ALU)   r_waitCnt <= '0;
        else                               r_waitCnt <= r_waitCnt + 1'b1;
    end

    // Free-running display scan; independent of the controller state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_scanCnt <= '0;
            r_digSel  <= '0;
        end else if (r_scanCnt == SCAN_W'(SCAN_DIV - 1)) begin
            r_scanCnt <= '0;
            r_digSel  <= r_digSel + 2'd1;
        end else begin
            r_scanCnt <= r_scanCnt + 1'b1;
        end
    end

    // Outputs: handshake, busy flag and the per-slot digit/dot selection.
    always_comb begin
        w_busy     = (r_state == ST_LAUNCH) || (r_state == ST_WAIT_ALU) || (r_state == ST_CONVERT);
        w_aluStart = (r_state == ST_LAUNCH);
        w_enabler  = ~(4'b0001 << r_digSel);
        w_num      = 4'hF;
        w_dot      = 1'b1;
        case (r_state)
            ST_ENTRY: begin
                case (r_digSel)
                    2'd0:    w_num = r_n1d0;
                    2'd1:    w_num = r_n1d1;
                    2'd2:    w_num = r_n2d0;
                    default: w_num = r_n2d1;
                endcase
                w_dot = (r_digSel != 2'd2);
            end
            ST_SHOW: begin
                w_num = r_err ? 4'hF : r_bcd[{r_digSel, 2'b00} +: 4];
                w_dot = !((r_digSel == 2'd3) && r_neg);
            end
            default: ;
        endcase
    end

    assign io_bus.n1dig0    = r_n1d0;
    assign io_bus.n1dig1    = r_n1d1;
    assign io_bus.n2dig0    = r_n2d0;
    assign io_bus.n2dig1    = r_n2d1;
    assign io_bus.alu_op    = r_aluOp;
    assign io_bus.alu_start = w_aluStart;
    assign io_bus.busy      = w_busy;
    assign io_bus.err       = r_err;
    assign io_bus.num       = w_num;
    assign io_bus.enabler   = w_enabler;
    assign io_bus.dot       = w_dot;

endmodule

// File: tb/tb_calc_controller.sv
// Self-checking bench for calc_controller. The bench plays the buttons and the
// ALU, keeps operands and results as plain integers, and derives display
// contents with decimal arithmetic.
module tb_calc_controller;
    localparam int SCAN_DIV    = 4;
    localparam int TIMEOUT_CYC = 16;
    localparam int MODE_ENTRY  = 0;
    localparam int MODE_BUSY   = 1;
    localparam int MODE_SHOW   = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int passCnt  = 0;
    int checkCnt = 0;
    int failCnt  = 0;
    int cyc      = 0;

    int mN1     = 0;
    int mN2     = 0;
    int mResult = 0;
    int mode    = MODE_ENTRY;
    bit mNeg    = 1'b0;
    bit mErr    = 1'b0;

    calc_controller_if bus ();

    calc_controller #(
        .SCAN_DIV    (SCAN_DIV),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus.master)
    );

    // Clock generation.
    always #5 clk = ~clk;

    // Cycles since reset released; the display slot is (cyc / SCAN_DIV) % 4.
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic applyStimulus(input logic [8:0] b);
        bus.B = b;
        tick(1);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCnt++;
        assert (obs === exp) passCnt++;
        else begin
            failCnt++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int digitOf(input int value, input int k);
        return (value / (10 ** k)) % 10;
    endfunction

    task automatic checkDisplay(input string tag);
        int         x;
        logic [3:0] expEn;
        logic [3:0] expNum;
        logic       expDot;
        x     = (cyc / SCAN_DIV) % 4;
        expEn = ~(4'b0001 << x);
        case (mode)
            MODE_ENTRY: begin
                case (x)
                    0:       expNum = 4'(mN1 % 10);
                    1:       expNum = 4'(mN1 / 10);
                    2:       expNum = 4'(mN2 % 10);
                    default: expNum = 4'(mN2 / 10);
                endcase
                expDot = (x != 2);
            end
            MODE_SHOW: begin
                expNum = mErr ? 4'hF : 4'(digitOf(mResult, x));
                expDot = !((x == 3) && mNeg);
            end
            default: begin
                expNum = 4'hF;
                expDot = 1'b1;
            end
        endcase
        checkOutput({tag, ".enabler"}, 32'(bus.enabler), 32'(expEn));
        checkOutput({tag, ".num"},     32'(bus.num),     32'(expNum));
        checkOutput({tag, ".dot"},     32'(bus.dot),     32'(expDot));
    endtask

    task automatic checkOperands(input string tag);
        checkOutput({tag, ".n1dig0"}, 32'(bus.n1dig0), 32'(mN1 % 10));
        checkOutput({tag, ".n1dig1"}, 32'(bus.n1dig1), 32'(mN1 / 10));
        checkOutput({tag, ".n2dig0"}, 32'(bus.n2dig0), 32'(mN2 % 10));
        checkOutput({tag, ".n2dig1"}, 32'(bus.n2dig1), 32'(mN2 / 10));
    endtask

    task automatic pressBtn(input int idx);
        applyStimulus(9'b1 << idx);
        applyStimulus(9'b0);
    endtask

    task automatic clearEntry();
        pressBtn(4);
        mN1  = 0;
        mN2  = 0;
        mode = MODE_ENTRY;
        mErr = 1'b0;
        mNeg = 1'b0;
        checkOutput("clear.busy", 32'(bus.busy), 32'(0));
        checkOutput("clear.err",  32'(bus.err),  32'(0));
        checkOperands("clear");
    endtask

    // Press counts per digit button; each digit ends at presses mod 10.
    task automatic enterOperands(input int p0, input int p1, input int p2, input int p3);
        clearEntry();
        repeat (p0) pressBtn(0);
        repeat (p1) pressBtn(1);
        repeat (p2) pressBtn(2);
        repeat (p3) pressBtn(3);
        mN1 = (p1 % 10) * 10 + (p0 % 10);
        mN2 = (p3 % 10) * 10 + (p2 % 10);
        checkOperands("entry");
        checkDisplay("entry");
    endtask

    // Launch via button pattern pat, answer as the ALU lat cycles after start,
    // then follow conversion into SHOW and scan all four digits.
    task automatic runOp(input logic [8:0] pat, input int opIdx, input int lat,
                         input bit ovf, input bit doneInLaunch);
        int r;
        bit n;
        n = 1'b0;
        case (opIdx)
            0: r = mN1 + mN2;
            1: begin
                r = (mN1 >= mN2) ? mN1 - mN2 : mN2 - mN1;
                n = (mN1 < mN2);
            end
            2: r = mN1 * mN2;
            default: r = (mN2 == 0) ? 0 : mN1 / mN2;
        endcase
        if (ovf) r = 12000;

        applyStimulus(pat);
        mode = MODE_BUSY;
        checkOutput("launch.start", 32'(bus.alu_start), 32'(1));
        checkOutput("launch.busy",  32'(bus.busy),      32'(1));
        checkOutput("launch.op",    32'(bus.alu_op),    32'(opIdx));
        checkOperands("launch");
        checkDisplay("launch");
        if (doneInLaunch) begin
            bus.alu_done   = 1'b1;
            bus.alu_result = 14'd777;
        end
        applyStimulus(9'b0);
        bus.alu_done = 1'b0;
        checkOutput("wait.start", 32'(bus.alu_start), 32'(0));
        checkOutput("wait.busy",  32'(bus.busy),      32'(1));
        if (lat > 1) tick(lat - 1);
        checkOutput("wait.busy2", 32'(bus.busy), 32'(1));
        bus.alu_done   = 1'b1;
        bus.alu_result = 14'(r);
        bus.alu_neg    = n;
        for (int i = 0; i < 14; i++) begin
            tick(1);
            if (i == 0) bus.alu_done = 1'b0;
            checkOutput("convert.busy", 32'(bus.busy), 32'(1));
            if (i < 2) begin
                checkOperands("convert");
                checkDisplay("convert");
            end
        end
        tick(1);
        mode    = MODE_SHOW;
        mResult = r;
        mNeg    = n;
        mErr    = (r > 9999) || ((opIdx == 3) && (mN2 == 0));
        checkOutput("show.busy",  32'(bus.busy),      32'(0));
        checkOutput("show.err",   32'(bus.err),       32'(mErr));
        checkOutput("show.start", 32'(bus.alu_start), 32'(0));
        for (int i = 0; i < 4 * SCAN_DIV; i++) begin
            checkDisplay("show");
            tick(1);
        end
    endtask

    initial begin
        bus.B          = 9'b0;
        bus.alu_done   = 1'b0;
        bus.alu_result = 14'd0;
        bus.alu_neg    = 1'b0;
        rst            = 1'b1;
        tick(2);

        $display("[TB] reset state");
        checkOutput("rst.enabler", 32'(bus.enabler),   32'(4'b1110));
        checkOutput("rst.num",     32'(bus.num),       32'(0));
        checkOutput("rst.dot",     32'(bus.dot),       32'(1));
        checkOutput("rst.busy",    32'(bus.busy),      32'(0));
        checkOutput("rst.err",     32'(bus.err),       32'(0));
        checkOutput("rst.start",   32'(bus.alu_start), 32'(0));
        checkOutput("rst.op",      32'(bus.alu_op),    32'(0));
        checkOperands("rst");
        rst = 1'b0;
        tick(1);

        $display("[TB] digit entry and wrap");
        enterOperands(11, 0, 0, 2);
        for (int i = 0; i < 4 * SCAN_DIV; i++) begin
            tick(1);
            checkDisplay("scan.entry");
        end

        $display("[TB] add with handshake, SHOW ignores digits, relaunch");
        enterOperands(7, 4, 5, 8);
        runOp(9'b1 << 5, 0, 3, 1'b0, 1'b1);
        pressBtn(0);
        checkOperands("show.digitIgnored");
        checkOutput("show.stayShow", 32'(bus.busy), 32'(0));
        checkDisplay("show.digitIgnored");
        runOp(9'b1 << 6, 1, 2, 1'b0, 1'b0);

        $display("[TB] simultaneous edges");
        enterOperands(3, 0, 0, 0);
        runOp((9'b1 << 6) | (9'b1 << 8) | 9'b1, 1, 1, 1'b0, 1'b0);
        enterOperands(5, 2, 1, 0);
        applyStimulus((9'b1 << 4) | (9'b1 << 6) | (9'b1 << 8) | 9'b1);
        mN1 = 0;
        mN2 = 0;
        checkOutput("clrWins.busy",  32'(bus.busy),      32'(0));
        checkOutput("clrWins.start", 32'(bus.alu_start), 32'(0));
        checkOperands("clrWins");
        applyStimulus(9'b0);
        checkOutput("clrWins.busy2", 32'(bus.busy), 32'(0));

        $display("[TB] error cases");
        enterOperands(5, 2, 0, 0);
        runOp(9'b1 << 8, 3, 2, 1'b0, 1'b0);
        clearEntry();
        enterOperands(1, 1, 1, 1);
        runOp(9'b1 << 5, 0, 1, 1'b1, 1'b0);
        clearEntry();

        $display("[TB] abort from WAIT_ALU keeps operands");
        enterOperands(4, 3, 2, 1);
        applyStimulus(9'b1 << 7);
        applyStimulus(9'b0);
        tick(3);
        applyStimulus(9'b1 << 4);
        mode = MODE_ENTRY;
        checkOutput("abort.busy", 32'(bus.busy), 32'(0));
        checkOperands("abort");
        applyStimulus(9'b0);
        checkDisplay("abort");

        $display("[TB] ALU never answers");
        applyStimulus(9'b1 << 5);
        applyStimulus(9'b0);
        mode = MODE_BUSY;
        checkOutput("noDone.busy0", 32'(bus.busy), 32'(1));
`ifdef CALC_CTRL_TIMEOUT_EN
        for (int i = 1; i < TIMEOUT_CYC; i++) begin
            tick(1);
            checkOutput("timeout.stillBusy", 32'(bus.busy), 32'(1));
        end
        tick(1);
        mode = MODE_SHOW;
        mErr = 1'b1;
        mNeg = 1'b0;
        checkOutput("timeout.busy", 32'(bus.busy), 32'(0));
        checkOutput("timeout.err",  32'(bus.err),  32'(1));
        for (int i = 0; i < 4 * SCAN_DIV; i++) begin
            checkDisplay("timeout.show");
            tick(1);
        end
        clearEntry();
`else
        for (int i = 0; i < 10; i++) begin
            tick(1000);
            checkOutput("noTimeout.busy", 32'(bus.busy), 32'(1));
        end
        applyStimulus(9'b1 << 4);
        mode = MODE_ENTRY;
        checkOutput("noTimeout.abort", 32'(bus.busy), 32'(0));
        checkOperands("noTimeout.abort");
        applyStimulus(9'b0);
`endif

        $display("[TB] randomized operations");
        for (int t = 0; t < 6; t++) begin
            int p0, p1, p2, p3, op, lat;
            p0  = int'($urandom_range(0, 12));
            p1  = int'($urandom_range(0, 12));
            p2  = int'($urandom_range(0, 12));
            p3  = int'($urandom_range(0, 12));
            op  = int'($urandom_range(0, 3));
            lat = int'($urandom_range(1, 5));
            enterOperands(p0, p1, p2, p3);
            runOp(9'b1 << (5 + op), op, lat, 1'b0, 1'b0);
            clearEntry();
        end

        $display("[TB] reset during CONVERT");
        enterOperands(9, 9, 9, 9);
        applyStimulus(9'b1 << 7);
        applyStimulus(9'b0);
        bus.alu_done   = 1'b1;
        bus.alu_result = 14'd9801;
        bus.alu_neg    = 1'b0;
        tick(1);
        bus.alu_done = 1'b0;
        tick(4);
        checkOutput("preRst.busy", 32'(bus.busy), 32'(1));
        rst = 1'b1;
        tick(1);
        mN1  = 0;
        mN2  = 0;
        mode = MODE_ENTRY;
        mErr = 1'b0;
        mNeg = 1'b0;
        checkOutput("midRst.busy",    32'(bus.busy),      32'(0));
        checkOutput("midRst.start",   32'(bus.alu_start), 32'(0));
        checkOutput("midRst.enabler", 32'(bus.enabler),   32'(4'b1110));
        checkOutput("midRst.num",     32'(bus.num),       32'(0));
        checkOutput("midRst.dot",     32'(bus.dot),       32'(1));
        checkOutput("midRst.err",     32'(bus.err),       32'(0));
        checkOperands("midRst");
        rst = 1'b0;
        tick(1);
        checkDisplay("postRst");

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end
endmodule
